// File: rtl/mult_share_arbiter_if.sv
// Bundle of the request, multiplier and response signals of mult_share_arbiter.
//   req_*  : per-requester valid/ready handshake with packed operands (requester i at
//            [i*DATA_W +: DATA_W])
//   mul_*  : start/enable/done handshake to one shared sequential multiplier
//   rsp_*  : valid/ready response carrying requester id, product and timeout flag
//   busy   : arbiter is not idle
// slave is the arbiter's view; master is the surrounding system's view.
interface mult_share_arbiter_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 2
);
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*DATA_W-1:0] req_a;
  logic [N*DATA_W-1:0] req_b;
  logic                mul_start;
  logic                mul_enable;
  logic [DATA_W-1:0]   mul_a;
  logic [DATA_W-1:0]   mul_b;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [2*DATA_W-1:0] rsp_product;
  logic                rsp_err;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_product, rsp_ready,
    output req_ready, mul_start, mul_enable, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_product, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_product, rsp_ready,
    input  req_ready, mul_start, mul_enable, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_product, rsp_err, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier between N requesters.
// Round-robin picks a requester in IDLE, latches its operands, pulses mul_start, waits for
// mul_done (bounded by TIMEOUT cycles) and returns the product tagged with the requester id
// through a valid/ready response. A timeout flushes the multiplier (mul_enable low) and
// responds with rsp_err=1 and a zero product.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : request / multiplier / response bundle (slave view)
module mult_share_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  mult_share_arbiter_if.slave  bus_io
);
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAbort, StResp} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [2*DATA_W-1:0] rsp_product_q, rsp_product_d;
  logic                rsp_err_q, rsp_err_d;

  logic [2*N-1:0]      req_dbl;
  logic [N-1:0]        req_rot;
  logic                win_found;
  int unsigned         win_pos;
  logic [ID_W-1:0]     win_idx;
  logic [DATA_W-1:0]   a_sel, b_sel;
  int unsigned         ptr_nxt;

  // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the first set
  // bit; its offset from rr_ptr (mod N) is the winner.
  always_comb begin
    req_dbl   = {bus_io.req_valid, bus_io.req_valid} >> rr_ptr_q;
    req_rot   = req_dbl[N-1:0];
    win_found = 1'b0;
    win_pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_pos   = 32'(rr_ptr_q) + k;
      end
    end
    if (win_pos >= N) win_pos = win_pos - N;
    win_idx = ID_W'(win_pos);
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_idx == ID_W'(i)) begin
        a_sel = bus_io.req_a[i*DATA_W +: DATA_W];
        b_sel = bus_io.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_nxt = 32'(rsp_id_q) + 1;
    if (ptr_nxt >= N) ptr_nxt = 0;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          mul_a_d  = a_sel;
          mul_b_d  = b_sel;
          rsp_id_d = win_idx;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        // done takes priority over a simultaneous timeout
        if (bus_io.mul_done) begin
          rsp_product_d = bus_io.mul_product;
          rsp_err_d     = 1'b0;
          state_d       = StResp;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        rsp_product_d = '0;
        rsp_err_d     = 1'b1;
        state_d       = StResp;
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          rr_ptr_d = ID_W'(ptr_nxt);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // Grant is combinational; masked by rst so every output reads zero during reset.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      bus_io.req_ready[i] = !rst && (state_q == StIdle) && win_found && (win_idx == ID_W'(i));
    end
  end

  assign bus_io.mul_start   = (state_q == StIssue);
  assign bus_io.mul_enable  = (state_q == StIssue) || (state_q == StWait);
  assign bus_io.mul_a       = mul_a_q;
  assign bus_io.mul_b       = mul_b_q;
  assign bus_io.rsp_valid   = (state_q == StResp);
  assign bus_io.rsp_id      = rsp_id_q;
  assign bus_io.rsp_product = rsp_product_q;
  assign bus_io.rsp_err     = rsp_err_q;
  assign bus_io.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised scoreboard bench for mult_share_arbiter with a behavioural multiplier stub.
module tb_mult_share_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned NEVER   = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_share_arbiter_if #(.N(N), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  mult_share_arbiter #(.N(N), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    int unsigned id;
    logic [31:0] prod;
    logic        err;
    int unsigned dly;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned dly_q[$];
  int unsigned glog[$];
  int          n_chk = 0;
  int          n_pass = 0;

  // stimulus state and knobs
  logic [N-1:0]      rv;
  logic [DATA_W-1:0] ra[N];
  logic [DATA_W-1:0] rb[N];
  int unsigned p_req, p_rdy, p_drop, p_spur, dmode;
  bit          keep_ops;

  // reference model state
  int unsigned m_ptr;
  bit          in_flight;
  // snapshots taken by the monitor on the falling edge
  logic [N-1:0] sv_s, rr_s;
  bit           st_s, en_s, if_s, snap_ok;
  bit           acc_prev, prev_stall;
  logic [ID_W-1:0] p_id;
  logic [31:0]  p_prod;
  logic         p_err;
  int unsigned  start_cnt, wait_cnt, abort_cnt;
  int unsigned  last_id;
  logic [31:0]  last_prod;
  logic         last_err;
  // multiplier stub
  bit           pend;
  int unsigned  cnt;
  logic [31:0]  pprod;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic int unsigned rr_pick(input logic [N-1:0] v, input int unsigned p,
                                          output bit found);
    int unsigned j;
    found   = 1'b0;
    rr_pick = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (!found && v[j[ID_W-1:0]]) begin
        found   = 1'b1;
        rr_pick = j;
      end
    end
  endfunction

  function automatic int unsigned pick_delay();
    int unsigned r;
    case (dmode)
      0: return 6;
      1: return 1 + $urandom % 8;
      2: return NEVER;
      4: return TIMEOUT;
      default: begin
        r = $urandom % 10;
        if (r == 0) return TIMEOUT;
        if (r == 1) return TIMEOUT + 1;
        if (r == 2) return NEVER;
        return 1 + $urandom % TIMEOUT;
      end
    endcase
  endfunction

  task automatic drive();
    bus.req_valid = rv;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DATA_W +: DATA_W] = ra[i];
      bus.req_b[i*DATA_W +: DATA_W] = rb[i];
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks protocol rules.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      snap_ok = 1'b0;
    end else begin
      sv_s    = bus.req_valid;
      rr_s    = bus.req_ready;
      st_s    = bus.mul_start;
      en_s    = bus.mul_enable;
      if_s    = in_flight;
      snap_ok = 1'b1;
      check("busy", 64'(bus.busy), 64'(in_flight));
      if (in_flight) check("ready_while_busy", 64'(bus.req_ready), 64'd0);
      check("start_after_accept", 64'(bus.mul_start), 64'(acc_prev));
      acc_prev = |(bus.req_ready & bus.req_valid);
      if (bus.mul_start) start_cnt++;
      if (bus.mul_enable && !bus.mul_start) wait_cnt++;
      if (in_flight && !bus.mul_enable && !bus.rsp_valid) abort_cnt++;
      if (prev_stall) begin
        check("rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
        check("rsp_id_stable", 64'(bus.rsp_id), 64'(p_id));
        check("rsp_product_stable", 64'(bus.rsp_product), 64'(p_prod));
        check("rsp_err_stable", 64'(bus.rsp_err), 64'(p_err));
      end
      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      p_id   = bus.rsp_id;
      p_prod = bus.rsp_product;
      p_err  = bus.rsp_err;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: got id %0d with no outstanding request", bus.rsp_id);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          check("rsp_product", 64'(bus.rsp_product), 64'(e.prod));
          check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          check("start_count", 64'(start_cnt), 64'd1);
          check("wait_cycles", 64'(wait_cnt), 64'(e.err ? TIMEOUT : e.dly));
          check("abort_cycles", 64'(abort_cnt), 64'(e.err));
          last_id   = e.id;
          last_prod = bus.rsp_product;
          last_err  = bus.rsp_err;
          m_ptr     = (e.id + 1) % N;
        end
        in_flight = 1'b0;
        start_cnt = 0;
        wait_cnt  = 0;
        abort_cnt = 0;
      end
    end
  end

  // One cycle of stimulus: scoreboard push on acceptance, multiplier stub, requesters.
  task automatic step();
    bit          found;
    int unsigned w, d;
    logic [N-1:0] one, exp_rr;
    exp_t        e;
    @(posedge clk);
    #1;
    bus.mul_done = 1'b0;
    if (snap_ok) begin
      if (!if_s) begin
        w      = rr_pick(sv_s, m_ptr, found);
        one    = 1;
        exp_rr = found ? (one << w) : '0;
        check("req_ready_grant", 64'(rr_s), 64'(exp_rr));
        if (found) begin
          d      = pick_delay();
          e.id   = w;
          e.dly  = d;
          e.err  = (d > TIMEOUT);
          e.prod = e.err ? 32'd0 : (32'(ra[w]) * 32'(rb[w]));
          exp_q.push_back(e);
          dly_q.push_back(d);
          glog.push_back(w);
          in_flight = 1'b1;
        end
      end
      if (st_s) begin
        cnt   = (dly_q.size() > 0) ? dly_q.pop_front() : NEVER;
        pend  = 1'b1;
        pprod = 32'(bus.mul_a) * 32'(bus.mul_b);
      end else if (pend && !en_s) begin
        pend = 1'b0;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.mul_done    = 1'b1;
          bus.mul_product = pprod;
          pend            = 1'b0;
        end
      end else if ($urandom % 100 < p_spur) begin
        bus.mul_done    = 1'b1;
        bus.mul_product = $urandom;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (snap_ok && sv_s[i] && rr_s[i]) rv[i] = 1'b0;
      else if (rv[i] && ($urandom % 100 < p_drop)) rv[i] = 1'b0;
      if (!rv[i] && ($urandom % 100 < p_req)) begin
        rv[i] = 1'b1;
        if (!keep_ops) begin
          ra[i] = DATA_W'($urandom);
          rb[i] = DATA_W'($urandom);
        end
      end
    end
    bus.rsp_ready = ($urandom % 100 < p_rdy);
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {bus.mul_a, bus.mul_b, bus.rsp_product}, 64'd0);
    check({tag, "_ctl"}, 64'({bus.rsp_id, bus.rsp_err, bus.mul_start, bus.mul_enable,
                              bus.rsp_valid, bus.busy, bus.req_ready}), 64'd0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    dly_q.delete();
    m_ptr      = 0;
    in_flight  = 1'b0;
    pend       = 1'b0;
    acc_prev   = 1'b0;
    prev_stall = 1'b0;
    start_cnt  = 0;
    wait_cnt   = 0;
    abort_cnt  = 0;
  endtask

  task automatic set_knobs(input int unsigned req, input int unsigned rdy,
                           input int unsigned drp, input int unsigned spur,
                           input int unsigned dm);
    p_req  = req;
    p_rdy  = rdy;
    p_drop = drp;
    p_spur = spur;
    dmode  = dm;
  endtask

  initial begin
    rst             = 1'b1;
    rv              = '1;
    keep_ops        = 1'b1;
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    bus.rsp_ready   = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra[i] = 16'h1234;
      rb[i] = DATA_W'(i);
    end
    drive();
    clear_model();
    set_knobs(100, 100, 0, 0, 1);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // All four requesting continuously: strict rotation 0,1,2,3,0.
    run(70);
    if (glog.size() < 5) begin
      n_chk++;
      $display("FAIL rr_order: got %0d grants required at least 5", glog.size());
    end else begin
      for (int i = 0; i < 5; i++) check("rr_order", 64'(glog[i]), 64'(i % N));
    end
    set_knobs(0, 100, 0, 0, 1);
    run(60);

    // Single request, done 6 cycles after start.
    ra[0] = 16'h00FF;
    rb[0] = 16'h0010;
    rv    = 4'b0001;
    set_knobs(0, 100, 0, 0, 0);
    drive();
    run(25);
    check("single_product", 64'(last_prod), 64'h0000_0FF0);
    check("single_id", 64'(last_id), 64'd0);

    // Multiplier never answers: timeout abort.
    ra[1] = 16'hABCD;
    rb[1] = 16'h0003;
    rv    = 4'b0010;
    set_knobs(0, 100, 0, 0, 2);
    drive();
    run(30);
    check("timeout_err", 64'(last_err), 64'd1);
    check("timeout_product", 64'(last_prod), 64'd0);

    // Done in the last allowed WAIT cycle.
    ra[2] = 16'h1234;
    rb[2] = 16'h0002;
    rv    = 4'b0100;
    set_knobs(0, 100, 0, 0, 4);
    drive();
    run(30);
    check("collision_err", 64'(last_err), 64'd0);
    check("collision_product", 64'(last_prod), 64'h0000_2468);

    // Response stalled while requester 3 waits.
    ra[0] = 16'h0F0F;
    rb[0] = 16'h0101;
    rv    = 4'b0001;
    set_knobs(0, 0, 0, 0, 1);
    drive();
    run(12);
    rv[3] = 1'b1;
    ra[3] = 16'hFFFF;
    rb[3] = 16'hFFFF;
    drive();
    run(5);
    set_knobs(0, 100, 0, 0, 1);
    run(40);
    check("bp_last_id", 64'(last_id), 64'd3);
    check("bp_last_product", 64'(last_prod), 64'hFFFE_0001);

    // Random traffic with drops, spurious done pulses, stalls and timeouts.
    keep_ops = 1'b0;
    set_knobs(30, 60, 5, 10, 3);
    run(2500);

    // Reset in the middle of WAIT.
    set_knobs(30, 60, 0, 0, 2);
    for (int i = 0; i < 300 && !pend; i++) step();
    if (!pend) begin
      n_chk++;
      $display("FAIL reset_wait: no WAIT reached within bound");
    end else begin
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      clear_model();
      bus.mul_done = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
    end
    set_knobs(30, 70, 5, 10, 3);
    run(500);

    // Drain everything outstanding.
    set_knobs(0, 100, 0, 0, 1);
    run(200);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(in_flight), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
